// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider (seq_divider).
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    SIGN,
    DONE
  } div_state_e;

  // Iteration counter must hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sdiv_datapath.sv
// Restoring-division datapath: A/Q/M registers, trial subtractor and sign fix-up.
// Optional divide-by-zero shortcut compiled in with DIV_BY_ZERO_DET_EN.
module sdiv_datapath
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         iter,
  input  logic         fix,
`ifdef DIV_BY_ZERO_DET_EN
  input  logic         fix_dbz,
  output logic         m_zero,
`endif
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] a_q;
  logic [N-1:0] q_q;
  logic [N-1:0] m_q;
  logic         sq_q;
  logic         sr_q;
  logic [N:0]   trial;

  // A stays below M <= 2^(N-1), so N bits of A plus the shifted-in bit never overflow.
  assign trial = {a_q, q_q[N-1]} - {1'b0, m_q};

`ifdef DIV_BY_ZERO_DET_EN
  assign m_zero = (m_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (load) begin
        a_q  <= '0;
        q_q  <= dividend[N-1] ? -dividend : dividend;
        m_q  <= divisor[N-1] ? -divisor : divisor;
        sq_q <= dividend[N-1] ^ divisor[N-1];
        sr_q <= dividend[N-1];
      end else if (iter) begin
        if (!trial[N]) begin
          a_q <= trial[N-1:0];
          q_q <= {q_q[N-2:0], 1'b1};
        end else begin
          a_q <= {a_q[N-2:0], q_q[N-1]};
          q_q <= {q_q[N-2:0], 1'b0};
        end
      end

      if (fix) begin
        quotient  <= sq_q ? -q_q : q_q;
        remainder <= sr_q ? -a_q : a_q;
      end
`ifdef DIV_BY_ZERO_DET_EN
      // Q still holds |dividend| here, so re-applying its sign recovers the dividend.
      else if (fix_dbz) begin
        quotient  <= '1;
        remainder <= sr_q ? -q_q : q_q;
      end
`endif
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider top: FSM, iteration counter and start/done handshake.
// Define DIV_BY_ZERO_DET_EN to add the dbz port and the early divide-by-zero exit.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef DIV_BY_ZERO_DET_EN
  ,
  output logic         dbz
`endif
);

  localparam int CW = cnt_width(N);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          load, iter, fix;
`ifdef DIV_BY_ZERO_DET_EN
  logic          fix_dbz;
  logic          m_zero;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    iter    = 1'b0;
    fix     = 1'b0;
`ifdef DIV_BY_ZERO_DET_EN
    fix_dbz = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef DIV_BY_ZERO_DET_EN
        if (m_zero) begin
          fix_dbz = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
`else
        state_d = ITER;
`endif
      end
      ITER: begin
        iter = 1'b1;
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up exactly with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == LOAD) || (state_d == ITER) || (state_d == SIGN);
      done    <= (state_d == DONE);
      if (load)      cnt_q <= CW'(N);
      else if (iter) cnt_q <= cnt_q - CW'(1);
    end
  end

`ifdef DIV_BY_ZERO_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dbz <= 1'b0;
    else if (load)    dbz <= 1'b0;
    else if (fix_dbz) dbz <= 1'b1;
  end
`endif

  sdiv_datapath #(.N(N)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .iter      (iter),
    .fix       (fix),
`ifdef DIV_BY_ZERO_DET_EN
    .fix_dbz   (fix_dbz),
    .m_zero    (m_zero),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8) with a queue-based scoreboard.
module tb_seq_divider;

  localparam int N   = 8;
  localparam int LAT = N + 3;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done;
  logic [N-1:0] quotient, remainder;
`ifdef DIV_BY_ZERO_DET_EN
  logic         dbz;
`endif

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  int ca[10] = '{-100, 100, -100, -128, -128, 5, 7, -7, -128, 127};
  int cb[10] = '{7, -7, -7, -1, 1, 9, 0, 0, -128, 1};

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_BY_ZERO_DET_EN
    ,
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   qi, ri;
    e.z   = 1'b0;
    e.lat = LAT;
    if (b == 0) begin
`ifdef DIV_BY_ZERO_DET_EN
      qi    = -1;
      e.z   = 1'b1;
      e.lat = 2;
`else
      qi = (a < 0) ? 1 : -1;
`endif
      ri = a;
    end else begin
      qi = a / b;
      ri = a % b;
    end
    e.q = qi[N-1:0];
    e.r = ri[N-1:0];
    return e;
  endfunction

  // Drives one start pulse during an IDLE cycle; returns in cycle 1 (LOAD).
  task automatic issue(input int a, input int b);
    dividend = a[N-1:0];
    divisor  = b[N-1:0];
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start    = 1'b0;
  endtask

  // Called in cycle 1; returns in the done cycle (or after the cycle budget).
  task automatic await_done(output int cyc, output int busy_cyc);
    cyc      = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && cyc < 4 * LAT) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_flags: busy/done got %b expected 00", {busy, done});
    else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder} !== '0) $display("FAIL reset_data: q/r got %h expected 0", {quotient, remainder});
    else pass_cnt++;
`ifdef DIV_BY_ZERO_DET_EN
    total_cnt++;
    if (dbz !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", dbz);
    else pass_cnt++;
`endif
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_flags: busy/done got %b expected 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    exp_t e;
    int   cyc, bcyc;
    issue(100, 7);
    await_done(cyc, bcyc);
    e = sb.pop_front();
    total_cnt++;
    if (quotient !== e.q) $display("FAIL basic_q: got %0d expected %0d", $signed(quotient), $signed(e.q));
    else pass_cnt++;
    total_cnt++;
    if (remainder !== e.r) $display("FAIL basic_r: got %0d expected %0d", $signed(remainder), $signed(e.r));
    else pass_cnt++;
    total_cnt++;
    if (cyc != LAT) $display("FAIL basic_latency: done after %0d cycles expected %0d", cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (bcyc != N + 2 || busy !== 1'b0) $display("FAIL basic_busy: busy cycles %0d (busy at done %b) expected %0d (0)", bcyc, busy, N + 2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: done got %b expected 0 after one cycle", done);
    else pass_cnt++;
  endtask

  task automatic test_signs();
    exp_t e;
    int   cyc, bcyc, a, b;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        a = ca[i];
        b = cb[i];
      end else begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(1, 255)) - 128;
      end
      issue(a, b);
      await_done(cyc, bcyc);
      e = sb.pop_front();
      total_cnt++;
      if (quotient !== e.q) $display("FAIL sign_q %0d/%0d: got %0d expected %0d", a, b, $signed(quotient), $signed(e.q));
      else pass_cnt++;
      total_cnt++;
      if (remainder !== e.r) $display("FAIL sign_r %0d/%0d: got %0d expected %0d", a, b, $signed(remainder), $signed(e.r));
      else pass_cnt++;
      total_cnt++;
      if (cyc != e.lat) $display("FAIL sign_latency %0d/%0d: got %0d expected %0d", a, b, cyc, e.lat);
      else pass_cnt++;
`ifdef DIV_BY_ZERO_DET_EN
      total_cnt++;
      if (dbz !== e.z) $display("FAIL sign_dbz %0d/%0d: got %b expected %b", a, b, dbz, e.z);
      else pass_cnt++;
`endif
      tick();
    end
  endtask

  task automatic test_stable();
    exp_t prev, e;
    int   cyc, bcyc, diffs;
    issue(23, 4);
    await_done(cyc, bcyc);
    prev = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder} !== {prev.q, prev.r}) $display("FAIL stable_first: q/r got %0d/%0d expected %0d/%0d", quotient, remainder, prev.q, prev.r);
    else pass_cnt++;
    diffs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dividend = N'($urandom);
      divisor  = N'($urandom);
      if ({quotient, remainder} !== {prev.q, prev.r}) diffs++;
    end
    issue(-50, 3);
    cyc = 1;
    while (done !== 1'b1 && cyc < 4 * LAT) begin
      if ({quotient, remainder} !== {prev.q, prev.r}) diffs++;
      tick();
      cyc++;
    end
    total_cnt++;
    if (diffs != 0) $display("FAIL stable_hold: %0d cycles with changed outputs expected 0", diffs);
    else pass_cnt++;
    e = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL stable_next: q/r got %0d/%0d expected %0d/%0d", $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int   oa[3] = '{100, 50, -9};
    int   ob[3] = '{7, 5, 2};
    int   nd;
    exp_t e;
    nd    = 0;
    start = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (c % 12 == 0) begin
        dividend = oa[c / 12][N-1:0];
        divisor  = ob[c / 12][N-1:0];
        sb.push_back(model(oa[c / 12], ob[c / 12]));
      end else begin
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end
      if (c == 35) start = 1'b0;
      if (c > 0 && done === 1'b1) begin
        nd++;
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL b2b_extra: unexpected done at cycle %0d", c);
        end else begin
          e = sb.pop_front();
          if ({quotient, remainder} !== {e.q, e.r} || c % 12 != 11)
            $display("FAIL b2b_result: cycle %0d q/r got %0d/%0d expected %0d/%0d at cycle 11 mod 12", c, $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
          else pass_cnt++;
        end
      end
      tick();
    end
    total_cnt++;
    if (nd != 3) $display("FAIL b2b_count: got %0d done pulses expected 3", nd);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_abort();
    exp_t e;
    int   cyc, bcyc, nd;
    issue(100, 7);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL abort_flags: busy/done got %b expected 00", {busy, done});
    else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder} !== '0) $display("FAIL abort_data: q/r got %h expected 0", {quotient, remainder});
    else pass_cnt++;
    sb.delete();
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    total_cnt++;
    if (nd != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", nd);
    else pass_cnt++;
    rst_n = 1'b1;
    issue(50, 5);
    await_done(cyc, bcyc);
    e = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc != LAT)
      $display("FAIL abort_restart: q/r got %0d/%0d after %0d cycles expected %0d/%0d after %0d", $signed(quotient), $signed(remainder), cyc, $signed(e.q), $signed(e.r), LAT);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_stable();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
